// File: rtl/trd_sched.sv
// ----------------------------------------------------------------------------
// trd_sched - per-thread fetch scheduler for the 8-thread pipeline.
//
// Holds the thread-activity mask and one PC per thread. Each unstalled cycle
// the next active thread is picked round-robin (starting after the last
// issued thread) and {pc_if, trd_if, valid_if} are registered for IF.
// EXE-stage jump redirects and MEM-stage thread-control ops (START, KILL,
// EXIT) update the per-thread state, even while stalled.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold fetch outputs and round-robin pointer
//   jmp_en_exe      redirect thread trd_exe to jmp_pc_exe
//   jmp_pc_exe      redirect target
//   trd_exe         thread owning the redirect
//   trd_ctrl_mem    thread op: 001 START, 010 KILL, 011 EXIT, others no-op
//   obj_trd_mem     target thread for START/KILL
//   new_pc_mem      start PC for START
//   trd_mem         issuing thread, EXIT target
//   pc_if, trd_if   registered fetch PC and thread id
//   valid_if        registered fetch slot valid
//   active_mask     bit t set = thread t active
//   all_idle        no thread active (combinational)
// ----------------------------------------------------------------------------
module trd_sched #(
    parameter int unsigned NUM_TRD  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jmp_en_exe,
    input  logic [31:0] jmp_pc_exe,
    input  logic [2:0]  trd_exe,
    input  logic [2:0]  trd_ctrl_mem,
    input  logic [2:0]  obj_trd_mem,
    input  logic [31:0] new_pc_mem,
    input  logic [2:0]  trd_mem,
    output logic [31:0] pc_if,
    output logic [2:0]  trd_if,
    output logic        valid_if,
    output logic [7:0]  active_mask,
    output logic        all_idle
);

    localparam logic [2:0] OP_START = 3'b001;
    localparam logic [2:0] OP_KILL  = 3'b010;
    localparam logic [2:0] OP_EXIT  = 3'b011;

    logic [NUM_TRD-1:0] active_q, active_d;
    logic [31:0]        pc_q [NUM_TRD];
    logic [31:0]        pc_d [NUM_TRD];
    logic [2:0]         last_q;

    logic               sel_found;
    logic [2:0]         sel;
    logic [2:0]         idx;
    logic [31:0]        ipc;
    logic               issue;

    // Round-robin pick: scan last_q+8 down to last_q+1 so the nearest active
    // thread after last_q wins; last_q itself (offset 8) is only reached when
    // it is the sole active thread.
    always_comb begin
        sel_found = 1'b0;
        sel       = last_q;
        idx       = '0;
        for (int i = NUM_TRD; i >= 1; i--) begin
            idx = last_q + 3'(i);
            if (active_q[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    // Same-cycle redirect bypass for the thread being issued.
    assign ipc   = (jmp_en_exe && (trd_exe == sel)) ? jmp_pc_exe : pc_q[sel];
    assign issue = !stall && sel_found;

    // Per-thread state; later assignments take priority over earlier ones.
    always_comb begin
        active_d = active_q;
        for (int t = 0; t < NUM_TRD; t++) begin
            pc_d[t] = pc_q[t];
            if (jmp_en_exe && (trd_exe == 3'(t))) begin
                pc_d[t] = jmp_pc_exe;
            end
            // ipc already carries the bypassed jump target when trd_exe == sel.
            if (issue && (sel == 3'(t))) begin
                pc_d[t] = ipc + PC_INC;
            end
        end
        if (trd_ctrl_mem == OP_START) begin
            active_d[obj_trd_mem] = 1'b1;
            pc_d[obj_trd_mem]     = new_pc_mem;
        end
        if (trd_ctrl_mem == OP_KILL) begin
            active_d[obj_trd_mem] = 1'b0;
        end
        if (trd_ctrl_mem == OP_EXIT) begin
            active_d[trd_mem] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= NUM_TRD'(1);
            for (int t = 0; t < NUM_TRD; t++) begin
                pc_q[t] <= (t == 0) ? RESET_PC : 32'h0;
            end
        end else begin
            active_q <= active_d;
            for (int t = 0; t < NUM_TRD; t++) begin
                pc_q[t] <= pc_d[t];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if    <= 32'h0;
            trd_if   <= 3'd0;
            valid_if <= 1'b0;
            last_q   <= 3'd7;
        end else if (!stall) begin
            if (sel_found) begin
                pc_if    <= ipc;
                trd_if   <= sel;
                valid_if <= 1'b1;
                last_q   <= sel;
            end else begin
                valid_if <= 1'b0;
            end
        end
    end

    assign active_mask = active_q;
    assign all_idle    = (active_q == '0);

endmodule
